data_mem_responder: RTL and testbench

- Memory-side responder for the core's load/store path: accepts one word-wide request at a time and applies the 4-bit write mask per byte lane.
- Returns full 32-bit read words; sub-word extraction and sign/zero extension stay in the core-side load/store unit.
- Sits between the load/store unit and a synchronous word-organised data RAM, with a valid/ready request channel and a valid/ready response channel.
- Optional wait states emulate slow memory.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 153 +++++++++++++++
 tb/tb_data_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core-side unit and the data memory responder.
// master = load/store unit side, slave = memory responder side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder with byte-lane write masking and optional wait states.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  cnt_next;
  logic        accept;
  logic        commit;

  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wmask;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wmask;
  logic [IDX_W-1:0] acc_idx;
  logic        in_range;
  logic [31:0] old_word;
  logic [31:0] merged;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_wmask <= 4'd0;
    end else if (accept) begin
      cap_we    <= bus.req_we;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
      cap_wmask <= bus.req_wmask;
    end
  end

  // With no wait states the access happens on the acceptance edge, so the live request is used.
  always_comb begin
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_wmask = cap_wmask;
    if (state == IDLE) begin
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_wmask = bus.req_wmask;
    end
  end

  always_comb begin
    acc_idx  = acc_addr[IDX_W+1:2];
    in_range = ({1'b0, acc_addr} < LIMIT);
    old_word = mem[acc_idx];
    merged   = old_word;
    for (int i = 0; i < 4; i++) begin
      if (acc_we && acc_wmask[i]) begin
        merged[8*i +: 8] = acc_wdata[8*i +: 8];
      end
    end
  end

  // Array is deliberately left out of reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (commit && in_range && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wmask[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= in_range ? merged : 32'd0;
      err_q   <= ~in_range;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with 0, 2 and 3 wait states share one driver.
module tb_data_mem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] OOR   = 32'(DEPTH * 4);
  localparam logic [31:0] LAST  = 32'(DEPTH * 4 - 4);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_ready;
  int          sel;

  logic        req_ready_m;
  logic        resp_valid_m;
  logic [31:0] resp_rdata_m;
  logic        resp_err_m;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  data_mem_responder_if if0 ();
  data_mem_responder_if if2 ();
  data_mem_responder_if if3 ();

  assign if0.req_valid  = req_valid && (sel == 0);
  assign if0.req_we     = req_we;
  assign if0.req_addr   = req_addr;
  assign if0.req_wdata  = req_wdata;
  assign if0.req_wmask  = req_wmask;
  assign if0.resp_ready = resp_ready;
  assign if2.req_valid  = req_valid && (sel == 2);
  assign if2.req_we     = req_we;
  assign if2.req_addr   = req_addr;
  assign if2.req_wdata  = req_wdata;
  assign if2.req_wmask  = req_wmask;
  assign if2.resp_ready = resp_ready;
  assign if3.req_valid  = req_valid && (sel == 3);
  assign if3.req_we     = req_we;
  assign if3.req_addr   = req_addr;
  assign if3.req_wdata  = req_wdata;
  assign if3.req_wmask  = req_wmask;
  assign if3.resp_ready = resp_ready;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  always_comb begin
    case (sel)
      0: begin
        req_ready_m = if0.req_ready; resp_valid_m = if0.resp_valid;
        resp_rdata_m = if0.resp_rdata; resp_err_m = if0.resp_err;
      end
      2: begin
        req_ready_m = if2.req_ready; resp_valid_m = if2.resp_valid;
        resp_rdata_m = if2.resp_rdata; resp_err_m = if2.resp_err;
      end
      default: begin
        req_ready_m = if3.req_ready; resp_valid_m = if3.resp_valid;
        resp_rdata_m = if3.resp_rdata; resp_err_m = if3.resp_err;
      end
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected entry.
  always @(negedge clk) begin
    if (!rst && resp_valid_m && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp: got 0x%08h expected none", resp_rdata_m);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("resp_rdata", resp_rdata_m, e.rdata);
        check_output("resp_err", {31'd0, resp_err_m}, {31'd0, e.err});
      end
    end
  end

  task automatic issue(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
    bit ok;
    ok        = 1'b0;
    sel       = s;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_m) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ok) begin
      check_output("req_accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_resp(output int lat);
    bit found;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid_m) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    if (!found) begin
      check_output("resp_timeout", 32'd0, 32'd1);
    end
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int s, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mask,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    issue(s, we, addr, wdata, mask);
    wait_resp(lat);
    check_output("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_wmask  = 4'd0;
    resp_ready = 1'b1;
    sel        = 0;
    #2;
    check_output("rst_req_ready", {31'd0, req_ready_m}, 32'd1);
    check_output("rst_resp_valid", {31'd0, resp_valid_m}, 32'd0);
    check_output("rst_resp_rdata", resp_rdata_m, 32'd0);
    check_output("rst_resp_err", {31'd0, resp_err_m}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Round trip and lane masking, zero wait states.
    apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 0);
    apply_stimulus(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'hDEADBEAA, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0,        4'b1111, 32'hDEADBEAA, 1'b0, 0);
    apply_stimulus(0, 1'b1, 32'h10, 32'h00001234, 4'b0011, 32'hDEAD1234, 1'b0, 0);
    apply_stimulus(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'hDEAD1234, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0,        4'b0000, 32'hDEAD1234, 1'b0, 0);
    apply_stimulus(0, 1'b1, 32'h10, 32'hABCD0000, 4'b1100, 32'hABCD1234, 1'b0, 0);
    apply_stimulus(0, 1'b0, 32'h13, 32'h0,        4'b0000, 32'hABCD1234, 1'b0, 0);

    // Range boundary.
    apply_stimulus(0, 1'b1, LAST,   32'h12345678, 4'b1111, 32'h12345678, 1'b0, 0);
    apply_stimulus(0, 1'b0, OOR,    32'h0,        4'b0000, 32'h0,        1'b1, 0);
    apply_stimulus(0, 1'b1, OOR,    32'hCAFEF00D, 4'b1111, 32'h0,        1'b1, 0);
    apply_stimulus(0, 1'b0, LAST,   32'h0,        4'b0000, 32'h12345678, 1'b0, 0);

    // Backpressure with a competing request held on the bus.
    resp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'hABCD1234, err: 1'b0});
    issue(0, 1'b0, 32'h10, 32'h0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_resp_valid", {31'd0, resp_valid_m}, 32'd1);
      check_output("bp_resp_rdata", resp_rdata_m, 32'hABCD1234);
      check_output("bp_req_ready", {31'd0, req_ready_m}, 32'd0);
      @(posedge clk);
      #1;
      if (i == 0) begin
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h55AA55AA;
        req_wmask = 4'b1111;
        req_valid = 1'b1;
      end
    end
    exp_q.push_back('{rdata: 32'h55AA55AA, err: 1'b0});
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("post_hs_req_ready", {31'd0, req_ready_m}, 32'd1);
    check_output("post_hs_resp_valid", {31'd0, resp_valid_m}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    begin
      int lat;
      wait_resp(lat);
      check_output("bp_next_latency", 32'(lat), 32'd0);
    end
    apply_stimulus(0, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h55AA55AA, 1'b0, 0);

    // Wait states, back to back.
    apply_stimulus(2, 1'b1, 32'h40, 32'h01020304, 4'b1111, 32'h01020304, 1'b0, 2);
    apply_stimulus(2, 1'b0, 32'h40, 32'h0,        4'b0000, 32'h01020304, 1'b0, 2);
    apply_stimulus(2, 1'b1, 32'h40, 32'h0000EE00, 4'b0010, 32'h0102EE04, 1'b0, 2);

    // Reset while a write is still waiting: the write must be dropped.
    apply_stimulus(3, 1'b1, 32'h80, 32'h11111111, 4'b1111, 32'h11111111, 1'b0, 3);
    issue(3, 1'b1, 32'h80, 32'h22222222, 4'b1111);
    @(posedge clk);
    #1;
    check_output("wait_req_ready", {31'd0, req_ready_m}, 32'd0);
    check_output("wait_resp_valid", {31'd0, resp_valid_m}, 32'd0);
    rst = 1'b1;
    #1;
    check_output("async_rst_req_ready", {31'd0, req_ready_m}, 32'd1);
    check_output("async_rst_resp_valid", {31'd0, resp_valid_m}, 32'd0);
    check_output("async_rst_resp_rdata", resp_rdata_m, 32'd0);
    check_output("async_rst_resp_err", {31'd0, resp_err_m}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(3, 1'b0, 32'h80, 32'h0, 4'b0000, 32'h11111111, 1'b0, 3);

    // Reset during RESP: the committed write persists.
    resp_ready = 1'b0;
    issue(3, 1'b1, 32'h84, 32'h33333333, 4'b1111);
    begin
      int lat;
      wait_resp(lat);
      check_output("held_latency", 32'(lat), 32'd3);
    end
    rst = 1'b1;
    #1;
    check_output("resp_rst_resp_valid", {31'd0, resp_valid_m}, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    apply_stimulus(3, 1'b0, 32'h84, 32'h0, 4'b0000, 32'h33333333, 1'b0, 3);

    repeat (2) @(posedge clk);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
